// File: rtl/moldudp64_tx.sv
// rtl/moldudp64_tx.sv - MoldUDP64 transmit packet builder (header + length-prefixed messages to byte-packed stream)
module moldudp64_tx #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int ML_W       = 16,
  parameter int SID_W      = 80,
  parameter int SEQ_W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_v_i,
  output logic                  pkt_ready_o,
  input  logic [SID_W-1:0]      pkt_sid_i,
  input  logic [SEQ_W-1:0]      pkt_seq_i,
  input  logic [ML_W-1:0]       pkt_msg_cnt_i,
  input  logic                  mold_msg_v_i,
  output logic                  mold_msg_ready_o,
  input  logic                  mold_msg_start_i,
  input  logic [ML_W-1:0]       mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
  output logic                  upd_axis_tvalid_o,
  input  logic                  upd_axis_tready_i,
  output logic [AXI_DATA_W-1:0] upd_axis_tdata_o,
  output logic [AXI_KEEP_W-1:0] upd_axis_tkeep_o,
  output logic                  upd_axis_tlast_o,
  output logic                  upd_axis_tuser_o
);

  localparam int ACC_BYTES = 24;
  localparam int ACC_W     = ACC_BYTES * 8;
  localparam int INS_W     = ML_W + AXI_DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MSG   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [4:0]        r_fill;
  logic [4:0]        w_fill_nxt;
  logic [ML_W-1:0]   r_cnt;
  logic [ML_W-1:0]   w_cnt_nxt;
  logic [ML_W-1:0]   r_rem;
  logic [ML_W-1:0]   w_rem_nxt;
  logic [ML_W-1:0]   r_done;
  logic [ML_W-1:0]   w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic              w_tvalid;
  logic              w_tlast;
  logic [7:0]        w_keep;
  logic              w_out_fire;
  logic [4:0]        w_shift_fill;
  logic [ACC_W-1:0]  w_acc_sh;
  logic              w_pkt_fire;
  logic              w_msg_fire;
  logic [3:0]        w_pc;
  logic [3:0]        w_exp_pc;
  logic [INS_W-1:0]  w_ins;
  logic [3:0]        w_ins_n;
  logic [ML_W-1:0]   w_rem_base;
  logic [ML_W-1:0]   w_new_rem;
  logic              w_beat_err;
  logic              w_msg_last;
  logic [ML_W-1:0]   w_done_inc;

  // Output beat is always the bottom 8 bytes; everything forced low while reset is held.
  assign w_tvalid = ~reset & ((r_fill >= 5'd8) | ((r_state == S_FLUSH) & (r_fill != 5'd0)));
  assign w_tlast  = w_tvalid & (r_state == S_FLUSH) & (r_fill <= 5'd8);
  assign w_keep   = (r_fill >= 5'd8) ? 8'hFF : ((8'h01 << r_fill[2:0]) - 8'h01);
  assign w_out_fire = w_tvalid & upd_axis_tready_i;

  assign upd_axis_tvalid_o = w_tvalid;
  assign upd_axis_tlast_o  = w_tlast;
  assign upd_axis_tuser_o  = w_tlast & r_err;
  assign upd_axis_tkeep_o  = w_tvalid ? w_keep : 8'h00;
  assign upd_axis_tdata_o  = reset ? '0 : r_acc[AXI_DATA_W-1:0];

  // Accumulator view after this cycle's output beat (if any) has left.
  assign w_shift_fill = w_out_fire ? ((r_fill > 5'd8) ? (r_fill - 5'd8) : 5'd0) : r_fill;
  assign w_acc_sh     = w_out_fire ? {64'h0, r_acc[ACC_W-1:64]} : r_acc;

  // A message beat may add up to 10 bytes, so only accept when that still fits in 24.
  assign pkt_ready_o      = ~reset & (r_state == S_IDLE);
  assign mold_msg_ready_o = ~reset & (r_state == S_MSG) & (w_shift_fill <= 5'd14);
  assign w_pkt_fire       = pkt_v_i & pkt_ready_o;
  assign w_msg_fire       = mold_msg_v_i & mold_msg_ready_o;

  // Count of valid payload lanes in the incoming beat.
  always_comb begin
    w_pc = 4'd0;
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      w_pc = w_pc + {3'b000, mold_msg_mask_i[i]};
    end
  end

  // Bytes to append: start beats carry the 2 length bytes in front of the payload.
  assign w_ins      = mold_msg_start_i ? {mold_msg_data_i, mold_msg_len_i}
                                       : {{ML_W{1'b0}}, mold_msg_data_i};
  assign w_ins_n    = mold_msg_start_i ? (w_pc + 4'd2) : w_pc;
  assign w_rem_base = mold_msg_start_i ? mold_msg_len_i : r_rem;
  assign w_exp_pc   = (w_rem_base >= 16'd8) ? 4'd8 : w_rem_base[3:0];
  assign w_new_rem  = ({12'h000, w_pc} >= w_rem_base) ? '0 : (w_rem_base - {12'h000, w_pc});
  assign w_beat_err = (mold_msg_start_i & (r_rem != '0))
                    | (~mold_msg_start_i & (r_rem == '0))
                    | (w_pc != w_exp_pc);
  // A stray continuation beat with nothing outstanding does not complete a message.
  assign w_msg_last = (w_new_rem == '0) & (mold_msg_start_i | (r_rem != '0));
  assign w_done_inc = r_done + 16'd1;

  // Next-state and datapath update for packet framing.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = w_acc_sh;
    w_fill_nxt  = w_shift_fill;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_pkt_fire) begin
          w_acc_nxt  = {32'h0, pkt_msg_cnt_i, pkt_seq_i, pkt_sid_i};
          w_fill_nxt = 5'd20;
          w_cnt_nxt  = pkt_msg_cnt_i;
          w_rem_nxt  = '0;
          w_done_nxt = '0;
          w_err_nxt  = 1'b0;
          if ((pkt_msg_cnt_i == 16'h0000) || (pkt_msg_cnt_i == 16'hFFFF)) begin
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt = S_MSG;
          end
        end
      end
      S_MSG: begin
        if (w_msg_fire) begin
          for (int p = 0; p < ACC_BYTES; p++) begin
            int k;
            k = p - int'(w_shift_fill);
            if ((k >= 0) && (k < int'(w_ins_n))) begin
              w_acc_nxt[8*p +: 8] = w_ins[8*k +: 8];
            end
          end
          w_fill_nxt = w_shift_fill + {1'b0, w_ins_n};
          w_rem_nxt  = w_new_rem;
          w_err_nxt  = r_err | w_beat_err;
          if (w_msg_last) begin
            w_done_nxt = w_done_inc;
            if (w_done_inc == r_cnt) begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_tlast & w_out_fire) begin
          w_state_nxt = S_IDLE;
          w_fill_nxt  = 5'd0;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fill_nxt  = 5'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, fill level and message bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_fill <= 5'd0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rem  <= w_rem_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_moldudp64_tx.sv
// tb/tb_moldudp64_tx.sv - directed self-checking bench for moldudp64_tx
module tb_moldudp64_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_v_i;
  logic        pkt_ready_o;
  logic [79:0] pkt_sid_i;
  logic [63:0] pkt_seq_i;
  logic [15:0] pkt_msg_cnt_i;
  logic        mold_msg_v_i;
  logic        mold_msg_ready_o;
  logic        mold_msg_start_i;
  logic [15:0] mold_msg_len_i;
  logic [7:0]  mold_msg_mask_i;
  logic [63:0] mold_msg_data_i;
  logic        upd_axis_tvalid_o;
  logic        upd_axis_tready_i;
  logic [63:0] upd_axis_tdata_o;
  logic [7:0]  upd_axis_tkeep_o;
  logic        upd_axis_tlast_o;
  logic        upd_axis_tuser_o;

  moldudp64_tx dut (
    .clk               (clk),
    .reset             (reset),
    .pkt_v_i           (pkt_v_i),
    .pkt_ready_o       (pkt_ready_o),
    .pkt_sid_i         (pkt_sid_i),
    .pkt_seq_i         (pkt_seq_i),
    .pkt_msg_cnt_i     (pkt_msg_cnt_i),
    .mold_msg_v_i      (mold_msg_v_i),
    .mold_msg_ready_o  (mold_msg_ready_o),
    .mold_msg_start_i  (mold_msg_start_i),
    .mold_msg_len_i    (mold_msg_len_i),
    .mold_msg_mask_i   (mold_msg_mask_i),
    .mold_msg_data_i   (mold_msg_data_i),
    .upd_axis_tvalid_o (upd_axis_tvalid_o),
    .upd_axis_tready_i (upd_axis_tready_i),
    .upd_axis_tdata_o  (upd_axis_tdata_o),
    .upd_axis_tkeep_o  (upd_axis_tkeep_o),
    .upd_axis_tlast_o  (upd_axis_tlast_o),
    .upd_axis_tuser_o  (upd_axis_tuser_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic [15:0] len;
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;

  beat_t       bq[$];
  logic [7:0]  eq[$];
  logic [63:0] got_d[$];
  logic [7:0]  got_k[$];
  logic [79:0] cur_sid;
  logic [63:0] cur_seq;
  logic [15:0] cur_cnt;
  logic        exp_err;
  logic        toggle;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    cur_sid = sid;
    cur_seq = seq;
    cur_cnt = cnt;
    bq = {};
    eq = {};
    got_d = {};
    got_k = {};
    for (int i = 0; i < 10; i++) eq.push_back(sid[8*i +: 8]);
    for (int i = 0; i < 8; i++) eq.push_back(seq[8*i +: 8]);
    eq.push_back(cnt[7:0]);
    eq.push_back(cnt[15:8]);
  endtask

  // Payload byte j of a message is base+j; maxb truncates the message to that many beats.
  task automatic add_msg(input int len, input logic [7:0] base, input int maxb);
    beat_t b;
    int off, nb, n;
    eq.push_back(8'(len));
    eq.push_back(8'(len >> 8));
    off = 0;
    nb = 0;
    do begin
      n = len - off;
      if (n > 8) n = 8;
      b.start = (off == 0);
      b.len   = 16'(len);
      b.mask  = 8'((1 << n) - 1);
      b.data  = '0;
      for (int j = 0; j < n; j++) begin
        b.data[8*j +: 8] = base + 8'(off + j);
        eq.push_back(base + 8'(off + j));
      end
      bq.push_back(b);
      off += n;
      nb++;
    end while ((off < len) && (nb < maxb));
  endtask

  task automatic drive_all();
    int n;
    pkt_v_i       = 1'b1;
    pkt_sid_i     = cur_sid;
    pkt_seq_i     = cur_seq;
    pkt_msg_cnt_i = cur_cnt;
    n = 0;
    @(negedge clk);
    while (!pkt_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("pkt_accept", 64'(pkt_ready_o), 64'd1);
    @(posedge clk);
    #1;
    pkt_v_i = 1'b0;
    chk("first_beat_latency", 64'(upd_axis_tvalid_o), 64'd1);
    foreach (bq[i]) begin
      mold_msg_v_i     = 1'b1;
      mold_msg_start_i = bq[i].start;
      mold_msg_len_i   = bq[i].len;
      mold_msg_mask_i  = bq[i].mask;
      mold_msg_data_i  = bq[i].data;
      n = 0;
      @(negedge clk);
      while (!mold_msg_ready_o && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("msg_accept", 64'(mold_msg_ready_o), 64'd1);
      @(posedge clk);
      #1;
    end
    mold_msg_v_i     = 1'b0;
    mold_msg_start_i = 1'b0;
    mold_msg_mask_i  = 8'h00;
  endtask

  // Every cycle with tvalid is compared against the next expected 8 bytes, stalled or not.
  task automatic collect(output int nbeats);
    int idx, n, cyc;
    logic [63:0] ed, km;
    logic [7:0]  ek;
    logic        done, is_last;
    idx = 0;
    nbeats = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (upd_axis_tvalid_o) begin
        n = eq.size() - idx;
        if (n > 8) n = 8;
        if (n <= 0) begin
          chk("extra_beat", 64'd1, 64'd0);
          done = 1'b1;
        end else begin
          ed = '0;
          km = '0;
          for (int j = 0; j < n; j++) begin
            ed[8*j +: 8] = eq[idx + j];
            km[8*j +: 8] = 8'hFF;
          end
          ek = 8'((1 << n) - 1);
          is_last = ((idx + n) == eq.size());
          chk("tdata", upd_axis_tdata_o & km, ed);
          chk("tkeep", 64'(upd_axis_tkeep_o), 64'(ek));
          chk("tlast", 64'(upd_axis_tlast_o), 64'(is_last));
          chk("tuser", 64'(upd_axis_tuser_o), 64'(is_last & exp_err));
          if (upd_axis_tready_i) begin
            got_d.push_back(upd_axis_tdata_o);
            got_k.push_back(upd_axis_tkeep_o);
            idx += n;
            nbeats++;
            if (upd_axis_tlast_o) done = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      upd_axis_tready_i = toggle ? ~upd_axis_tready_i : 1'b1;
    end
    chk("packet_complete", 64'(done), 64'd1);
    upd_axis_tready_i = 1'b1;
  endtask

  task automatic run_pkt(input int exp_beats);
    int nb;
    fork
      drive_all();
      collect(nb);
    join
    chk("beat_count", 64'(nb), 64'(exp_beats));
  endtask

  task automatic reset_mid_packet();
    int f, c;
    fork
      drive_all();
      begin
        f = 0;
        c = 0;
        while (f < 3 && c < 100) begin
          @(negedge clk);
          c++;
          if (upd_axis_tvalid_o && upd_axis_tready_i) f++;
        end
        chk("beats_before_reset", 64'(f), 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(upd_axis_tvalid_o), 64'd0);
    chk("rst_tlast", 64'(upd_axis_tlast_o), 64'd0);
    chk("rst_pkt_ready", 64'(pkt_ready_o), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
    chk("post_rst_tvalid", 64'(upd_axis_tvalid_o), 64'd0);
  endtask

  initial begin
    reset             = 1'b1;
    pkt_v_i           = 1'b0;
    pkt_sid_i         = '0;
    pkt_seq_i         = '0;
    pkt_msg_cnt_i     = '0;
    mold_msg_v_i      = 1'b0;
    mold_msg_start_i  = 1'b0;
    mold_msg_len_i    = '0;
    mold_msg_mask_i   = '0;
    mold_msg_data_i   = '0;
    upd_axis_tready_i = 1'b1;
    exp_err           = 1'b0;
    toggle            = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(upd_axis_tvalid_o), 64'd0);
    chk("reset_tlast", 64'(upd_axis_tlast_o), 64'd0);
    chk("reset_tuser", 64'(upd_axis_tuser_o), 64'd0);
    chk("reset_tkeep", 64'(upd_axis_tkeep_o), 64'd0);
    chk("reset_tdata", upd_axis_tdata_o, 64'd0);
    chk("reset_pkt_ready", 64'(pkt_ready_o), 64'd0);
    chk("reset_msg_ready", 64'(mold_msg_ready_o), 64'd0);
    reset = 1'b0;
    #1;
    chk("after_reset_pkt_ready", 64'(pkt_ready_o), 64'd1);

    // Three-message packet, tready held high
    begin_pkt(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 16'd3);
    add_msg(16, 8'h10, 99);
    add_msg(8, 8'h20, 99);
    add_msg(10, 8'h30, 99);
    run_pkt(8);
    chk("three_msg_beat2", got_d[2], 64'h11100010_0003F0F0);
    chk("three_msg_beat0", got_d[0], 64'h00000000_DEADBEEF);
    chk("three_msg_last_keep", 64'(got_k[7]), 64'h0F);

    // Back-to-back heartbeat, count 0
    begin_pkt(80'h0102030405060708090A, 64'h1122334455667788, 16'h0000);
    run_pkt(3);
    chk("hb0_bytes16_19", 64'(got_d[2][31:0]), 64'h00001122);
    chk("hb0_last_keep", 64'(got_k[2]), 64'h0F);

    // End-of-session, count 0xFFFF
    begin_pkt(80'h0102030405060708090A, 64'h1122334455667788, 16'hFFFF);
    run_pkt(3);
    chk("hbF_bytes16_19", 64'(got_d[2][31:0]), 64'hFFFF1122);

    // Backpressure: tready toggles every cycle
    toggle = 1'b1;
    upd_axis_tready_i = 1'b0;
    begin_pkt(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 16'd3);
    add_msg(16, 8'h10, 99);
    add_msg(8, 8'h20, 99);
    add_msg(10, 8'h30, 99);
    run_pkt(8);
    chk("bp_beat2", got_d[2], 64'h11100010_0003F0F0);
    toggle = 1'b0;

    // Protocol error: new start while 4 bytes of a 12-byte message remain
    exp_err = 1'b1;
    begin_pkt(80'hABCD, 64'h5, 16'd2);
    add_msg(12, 8'h40, 1);
    add_msg(8, 8'h50, 99);
    add_msg(4, 8'h60, 99);
    run_pkt(6);
    chk("err_last_keep", 64'(got_k[5]), 64'h3F);
    exp_err = 1'b0;
    begin_pkt(80'h1, 64'h2, 16'h0000);
    run_pkt(3);

    // Reset after the third output beat, then a clean heartbeat
    begin_pkt(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 16'd3);
    add_msg(16, 8'h10, 99);
    reset_mid_packet();
    begin_pkt(80'h77, 64'h88, 16'h0000);
    run_pkt(3);

    // Zero-length message
    begin_pkt(80'h99, 64'hAA, 16'd1);
    add_msg(0, 8'h00, 99);
    run_pkt(3);
    chk("zl_last_keep", 64'(got_k[2]), 64'h3F);
    chk("zl_last_bytes", 64'(got_d[2][47:32]), 64'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/moldudp64_tx.md
# moldudp64_tx

Transmit-side MoldUDP64 packet builder. It takes one packet descriptor (session, sequence number, message count) and then a stream of MoldUDP64 messages as payload beats, and emits a byte-packed AXI-stream UDP payload: a 20-byte header, then each message as a 2-byte length plus payload. It sits between the message source and the UDP/IP transmit path. Its output byte layout is the one the MoldUDP64 receiver in this design decodes.

## Interface
- `AXI_DATA_W`, 64: output and message data width; only 64 is supported.
- `AXI_KEEP_W`, `AXI_DATA_W/8`: tkeep and message mask width.
- `ML_W`, 16: message length and message count width.
- `SID_W`, 80: session id width.
- `SEQ_W`, 64: sequence number width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `pkt_v_i` in 1: packet descriptor valid.
- `pkt_ready_o` out 1: descriptor accepted on `pkt_v_i & pkt_ready_o`.
- `pkt_sid_i` in SID_W: session id.
- `pkt_seq_i` in SEQ_W: sequence number.
- `pkt_msg_cnt_i` in ML_W: message count. 0 means heartbeat; 0xFFFF means end of session.
- `mold_msg_v_i` in 1: message beat valid.
- `mold_msg_ready_o` out 1: message beat accepted on `v & ready`.
- `mold_msg_start_i` in 1: first beat of a message.
- `mold_msg_len_i` in ML_W: payload length in bytes; sampled only on start beats.
- `mold_msg_mask_i` in AXI_KEEP_W: valid lanes; contiguous from lane 0.
- `mold_msg_data_i` in AXI_DATA_W: payload bytes; lane i is bits [8i+7:8i], lane 0 first.
- `upd_axis_tvalid_o` out 1, `upd_axis_tready_i` in 1: AXI-stream handshake.
- `upd_axis_tdata_o` out AXI_DATA_W, `upd_axis_tkeep_o` out AXI_KEEP_W, `upd_axis_tlast_o` out 1, `upd_axis_tuser_o` out 1: tuser=1 marks an errored packet.

## Operation
- **Byte order.** Byte order is lane 0 first. Each multi-byte field is placed least-significant byte in the lowest lane.
  - Header bytes 0-9 carry the sid, bytes 10-17 the seq, bytes 18-19 the count.
  - Each message is its 2 length bytes followed by its payload bytes.
- **Byte accumulator.** The block holds a 24-byte accumulator with a fill count (0..24).
  - Output beat = accumulator lanes 0-7.
  - When a beat is consumed, the accumulator shifts down by 8 bytes.
  - Accepted input bytes are appended at position `fill - 8*out_fire`.
  - On a start beat, the 2 length bytes are inserted ahead of the data.
- **FSM states:** IDLE, MSG, FLUSH.
- **IDLE:**
  - `pkt_ready_o`=1.
  - On descriptor accept, load the 20 header bytes, set fill=20 and latch the count.
  - Count 0 or 0xFFFF goes to FLUSH. Any other count goes to MSG.
- **MSG:**
  - `mold_msg_ready_o` = (`fill - 8*out_fire`) ≤ 14, so the worst-case append of 10 bytes never overflows.
  - Track message bytes remaining. The last beat of a message is the beat where remaining reaches 0.
  - A zero-length message is a single start beat with mask 0; only the 2 length bytes are appended.
  - When the last beat of message number `count` is accepted, go to FLUSH.
- **FLUSH:**
  - No input is accepted.
  - Emit full beats. The final beat carries fill bytes, with tkeep = (1<<fill)-1 and tlast=1.
  - Return to IDLE on the final handshake.
- **Error handling:**
  - Errors are: a start beat while bytes remain, a non-start beat when none remain, or a mask popcount that disagrees with the bytes remaining.
  - On any error, set a sticky error bit. The bytes are still packed per the mask.
  - tuser = error bit, presented on the tlast beat. tuser is 0 on all other beats.
  - The error bit clears on return to IDLE.
- **Invariant:** The block never emits a beat with tkeep=0.

## Timing
- **Reset values:** All outputs are 0 during reset: tvalid, tlast, tuser, tkeep, tdata, `pkt_ready_o`, `mold_msg_ready_o`. The state resets to IDLE with fill=0.
- **After reset:** `pkt_ready_o`=1 in the first cycle after reset deasserts.
- **Reset mid-packet:**
  - Abandons the packet.
  - tvalid drops the next cycle.
  - No tlast is generated.
- **tvalid:** tvalid = (fill≥8) | (FLUSH & fill>0), registered.
- **Latency:** A descriptor accepted in cycle N gives the first output beat valid in cycle N+1.
- **Backpressure:** While tvalid=1 and tready=0, tdata, tkeep, tlast and tuser stay stable.
- **Throughput:** The output runs at 1 beat/cycle, except for stalls caused by length insertion.
- **Simultaneous events:** An input accept and an output fire in the same cycle are both honoured.
- **Back-to-back packets:** A new descriptor is accepted in the cycle after the tlast handshake.

## Test plan
- **Three-message packet.** sid 0xDEADBEEF, seq 0xF0F0F0F0F0F0F0F0, count 3, messages of 16, 8 and 10 bytes, tready=1 → 8 beats (60 bytes).
  - Beat 2 is {2 payload bytes, 0x0010, 0x0003, 0xF0F0}.
  - Last beat has tkeep=0x0F, tlast=1, tuser=0.
- **Heartbeat.** Count 0 → 3 beats, last tkeep=0x0F, tlast=1, bytes 18-19 = 0x0000. Repeat with 0xFFFF: bytes 18-19 = 0xFFFF, same beat count.
- **Backpressure.** tready toggles every cycle during the three-message packet → identical byte sequence, outputs held while stalled, no overflow.
- **Protocol error.** A start beat arrives while 4 bytes of the previous message remain → tuser=1 only on the tlast beat. The next packet has tuser=0.
- **Reset mid-packet.** Reset after beat 3 → tvalid=0 next cycle and `pkt_ready_o`=1 after release. A following heartbeat packet comes out clean.
- **Zero-length message.** Count 1 with a 0-byte message → 22 bytes, 3 beats, last tkeep=0x3F, last two bytes 0x0000.
